du_transmit: RTL and testbench

Debug-unit transmit path: on request, serializes a snapshot of processor state (PC, cycle counter, register file, data memory) into a byte stream for the UART transmitter, one byte per UART handshake. Sits between the debug-unit control FSM and the UART TX core, and is the return path to the PC-side host of the protocol whose receive side loads the instruction count, instruction words and operating mode. Words go out LSB byte first, the same byte order the receive side uses to assemble instructions.

---
 rtl/du_transmit.sv | 182 ++++++++++++++++++
 tb/tb_du_transmit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/du_transmit.sv
// -----------------------------------------------------------------------------
// du_transmit
// Debug-unit transmit path. On a start request, serializes a snapshot of the
// processor state into a byte stream for the UART TX core. One byte is sent
// per UART handshake, and words go out LSB byte first.
//   Frame words: PC, cycle count, reg[0..N_REGS-1], mem[0..N_MEM-1]
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        asynchronous active-low reset
//   i_start        one-cycle frame request (ignored while busy)
//   i_pc           current PC, captured when the request is accepted
//   i_cycle_count  executed-cycle counter, captured with the PC
//   o_reg_addr     register-file read address
//   i_reg_data     register read data, valid one cycle after the address
//   o_mem_addr     data-memory word read address
//   i_mem_data     memory read data, valid one cycle after the address
//   o_tx_start     one-cycle strobe to the UART TX core
//   o_tx_data      byte to transmit, held until i_tx_done
//   i_tx_done      UART TX finished the current byte (pulse)
//   o_busy         high while a frame is in progress
//   o_send_done    one-cycle pulse when the frame is complete
// -----------------------------------------------------------------------------
module du_transmit #(
    parameter int NB_DATA     = 32,
    parameter int N_BITS      = 8,
    parameter int N_REGS      = 32,
    parameter int N_MEM       = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_MEM_ADDR = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycle_count,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic                   o_tx_start,
    output logic [N_BITS-1:0]      o_tx_data,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_send_done
);

    localparam int                W         = 2 + N_REGS + N_MEM;
    localparam int                NB_IDX    = $clog2(W);
    localparam logic [1:0]        LAST_BYTE = 2'(NB_DATA / N_BITS - 1);
    localparam logic [NB_IDX-1:0] LAST_WORD = NB_IDX'(W - 1);
    localparam logic [NB_IDX-1:0] FIRST_REG = NB_IDX'(2);
    localparam logic [NB_IDX-1:0] FIRST_MEM = NB_IDX'(2 + N_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [NB_IDX-1:0]      word_idx;
    logic [1:0]             byte_cnt;
    logic [NB_DATA-1:0]     pc_q;
    logic [NB_DATA-1:0]     cycles_q;
    logic [NB_DATA-1:0]     shift;

    logic [NB_IDX-1:0]      next_idx;
    logic [NB_REG_ADDR-1:0] next_reg_addr;
    logic [NB_MEM_ADDR-1:0] next_mem_addr;
    logic                   next_is_reg;
    logic                   next_is_mem;
    logic [NB_DATA-1:0]     word_src;

    // Index and read addresses of the word about to be entered in ADDR.
    always_comb begin
        next_idx      = (state == S_IDLE) ? '0 : word_idx + NB_IDX'(1);
        next_reg_addr = NB_REG_ADDR'(next_idx - FIRST_REG);
        next_mem_addr = NB_MEM_ADDR'(next_idx - FIRST_MEM);
        next_is_reg   = (next_idx >= FIRST_REG) && (next_idx < FIRST_MEM);
        next_is_mem   = (next_idx >= FIRST_MEM);
    end

    // Source of the word being loaded into the shift register in LATCH.
    always_comb begin
        if (word_idx == '0) begin
            word_src = pc_q;
        end else if (word_idx == NB_IDX'(1)) begin
            word_src = cycles_q;
        end else if (word_idx < FIRST_MEM) begin
            word_src = i_reg_data;
        end else begin
            word_src = i_mem_data;
        end
    end

    assign o_tx_data = shift[N_BITS-1:0];

    // Read addresses are registered on entry to ADDR so that they are already
    // present during the ADDR cycle; a synchronous read then returns the data
    // in the LATCH cycle, where it is captured.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            byte_cnt    <= '0;
            pc_q        <= '0;
            cycles_q    <= '0;
            shift       <= '0;
            o_reg_addr  <= '0;
            o_mem_addr  <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_send_done <= 1'b0;
        end else begin
            o_tx_start  <= 1'b0;
            o_send_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        pc_q     <= i_pc;
                        cycles_q <= i_cycle_count;
                        word_idx <= next_idx;
                        o_busy   <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    shift      <= word_src;
                    byte_cnt   <= '0;
                    o_tx_start <= 1'b1;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        shift <= shift >> N_BITS;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= S_NEXT;
                        end else begin
                            byte_cnt   <= byte_cnt + 2'd1;
                            o_tx_start <= 1'b1;
                            state      <= S_SEND;
                        end
                    end
                end
                S_NEXT: begin
                    if (word_idx == LAST_WORD) begin
                        o_send_done <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        word_idx <= next_idx;
                        if (next_is_reg) begin
                            o_reg_addr <= next_reg_addr;
                        end
                        if (next_is_mem) begin
                            o_mem_addr <= next_mem_addr;
                        end
                        state <= S_ADDR;
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_du_transmit.sv
// -----------------------------------------------------------------------------
// tb_du_transmit
// Bench for du_transmit. A small instance (N_REGS=2, N_MEM=1) is exercised by
// directed frames and watched by a frame-level model: the expected byte queue
// is built from the frame words, and the model also gives the expected strobe
// times, busy window and done pulse. A default-size instance sends one full
// frame with the address sweep checked.
// -----------------------------------------------------------------------------
module tb_du_transmit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int unsigned ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int checks = 0;
    int passed = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // ---------------- small instance ----------------
    logic        s_start, s_tx_done;
    logic [31:0] s_pc, s_cycle, s_reg_data, s_mem_data;
    logic [4:0]  s_reg_addr, s_mem_addr;
    logic        s_tx_start, s_busy, s_send_done;
    logic [7:0]  s_tx_data;
    logic [31:0] s_regs [32];
    logic [31:0] s_mems [32];

    du_transmit #(.N_REGS(2), .N_MEM(1)) dut_s (
        .i_clock(clk), .i_reset(rst_n), .i_start(s_start),
        .i_pc(s_pc), .i_cycle_count(s_cycle),
        .o_reg_addr(s_reg_addr), .i_reg_data(s_reg_data),
        .o_mem_addr(s_mem_addr), .i_mem_data(s_mem_data),
        .o_tx_start(s_tx_start), .o_tx_data(s_tx_data), .i_tx_done(s_tx_done),
        .o_busy(s_busy), .o_send_done(s_send_done)
    );

    // ---------------- default instance ----------------
    logic        d_start, d_tx_done;
    logic [31:0] d_pc, d_cycle, d_reg_data, d_mem_data;
    logic [4:0]  d_reg_addr, d_mem_addr;
    logic        d_tx_start, d_busy, d_send_done;
    logic [7:0]  d_tx_data;
    logic [31:0] d_regs [32];
    logic [31:0] d_mems [32];

    du_transmit dut_d (
        .i_clock(clk), .i_reset(rst_n), .i_start(d_start),
        .i_pc(d_pc), .i_cycle_count(d_cycle),
        .o_reg_addr(d_reg_addr), .i_reg_data(d_reg_data),
        .o_mem_addr(d_mem_addr), .i_mem_data(d_mem_data),
        .o_tx_start(d_tx_start), .o_tx_data(d_tx_data), .i_tx_done(d_tx_done),
        .o_busy(d_busy), .o_send_done(d_send_done)
    );

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        s_reg_data <= s_regs[s_reg_addr];
        s_mem_data <= s_mems[s_mem_addr];
        d_reg_data <= d_regs[d_reg_addr];
        d_mem_data <= d_mems[d_mem_addr];
    end

    // ---------------- UART TX responders ----------------
    bit s_auto = 1'b0;
    int s_delay = 10;
    initial begin
        s_tx_done = 1'b0;
        forever begin
            if (s_auto && rst_n && s_tx_start) begin
                bit ab;
                ab = 1'b0;
                for (int i = 0; i < s_delay; i++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                end
                if (!ab) begin
                    s_tx_done = 1'b1;
                    @(negedge clk);
                    s_tx_done = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        d_tx_done = 1'b0;
        forever begin
            if (rst_n && d_tx_start) begin
                @(negedge clk);
                d_tx_done = 1'b1;
                @(negedge clk);
                d_tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // ---------------- small-instance frame model and compare ----------------
    logic [7:0]  s_exp [$];
    logic [7:0]  s_log [$];
    bit          s_wait = 0, s_in_frame = 0, s_pending = 0, s_clear_next = 0;
    logic [7:0]  s_held;
    int unsigned s_start_edge = 0, s_done_edge = 0;
    int          s_nbyte = 0, s_strobes = 0, s_frames = 0;

    initial begin
        bit          dn;
        int unsigned exp_edge;
        logic [7:0]  e;
        forever begin
            @(posedge clk);
            dn = s_tx_done;
            #1;
            if (!rst_n) begin
                s_exp.delete();
                s_wait = 0; s_in_frame = 0; s_pending = 0; s_clear_next = 0;
                check(!s_busy && !s_tx_start && !s_send_done, "s_reset_quiet",
                      {s_busy, s_tx_start, s_send_done}, 0);
            end else begin
                if (s_pending && ecnt == s_start_edge) begin
                    s_in_frame = 1; s_pending = 0;
                end
                if (s_clear_next) begin
                    s_in_frame = 0; s_clear_next = 0;
                end
                check(s_busy == s_in_frame, "s_busy", s_busy, s_in_frame);
                if (s_wait && dn) begin
                    s_wait = 0; s_done_edge = ecnt;
                end
                if (s_tx_start) begin
                    check(!s_wait, "s_double_strobe", s_wait, 0);
                    if (s_nbyte == 0) exp_edge = s_start_edge + 2;
                    else if (s_nbyte % 4 == 0) exp_edge = s_done_edge + 3;
                    else exp_edge = s_done_edge;
                    check(ecnt == exp_edge, "s_strobe_latency", ecnt, exp_edge);
                    check(s_exp.size() != 0, "s_extra_strobe", s_exp.size(), 1);
                    if (s_exp.size() != 0) begin
                        e = s_exp.pop_front();
                        check(s_tx_data == e, "s_byte", s_tx_data, e);
                    end
                    s_held = s_tx_data;
                    s_wait = 1;
                    s_log.push_back(s_tx_data);
                    s_nbyte++;
                    s_strobes++;
                end else if (s_wait) begin
                    check(s_tx_data == s_held, "s_hold", s_tx_data, s_held);
                end
                if (s_send_done) begin
                    check(s_exp.size() == 0 && !s_wait && s_nbyte == 20, "s_done_when",
                          s_nbyte, 20);
                    check(ecnt == s_done_edge + 1, "s_done_latency", ecnt, s_done_edge + 1);
                    s_frames++;
                    s_clear_next = 1;
                end
            end
        end
    end

    task automatic s_send(input logic [31:0] pc, input logic [31:0] cy);
        logic [31:0] w [5];
        @(negedge clk);
        s_pc = pc; s_cycle = cy; s_start = 1'b1;
        s_start_edge = ecnt + 1; s_pending = 1; s_nbyte = 0;
        w = '{pc, cy, s_regs[0], s_regs[1], s_mems[0]};
        foreach (w[i]) for (int b = 0; b < 4; b++) s_exp.push_back(w[i][8*b +: 8]);
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic wait_s_frames(input int n, input int limit, input string name);
        for (int i = 0; i < limit && s_frames < n; i++) @(negedge clk);
        check(s_frames >= n, name, s_frames, n);
    endtask

    // ---------------- default-instance compare ----------------
    logic [7:0] d_exp [$];
    int         d_nbyte = 0, d_frames = 0;

    initial begin
        int         w;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && d_tx_start) begin
                w = d_nbyte / 4;
                if (d_nbyte % 4 == 0 && w >= 2 && w < 34)
                    check(d_reg_addr == 5'(w - 2), "d_reg_addr", d_reg_addr, w - 2);
                if (d_nbyte % 4 == 0 && w >= 34)
                    check(d_mem_addr == 5'(w - 34) && d_reg_addr == 5'd31, "d_mem_addr",
                          {d_reg_addr, d_mem_addr}, {5'd31, 5'(w - 34)});
                check(d_exp.size() != 0, "d_extra_strobe", d_exp.size(), 1);
                if (d_exp.size() != 0) begin
                    e = d_exp.pop_front();
                    check(d_tx_data == e, "d_byte", d_tx_data, e);
                end
                d_nbyte++;
            end
            if (rst_n && d_send_done) d_frames++;
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] lit [20] = '{8'h10, 8'h00, 8'h40, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00,
                             8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        int base;
        logic [31:0] w [66];

        rst_n = 1'b0;
        s_start = 1'b0; s_pc = '0; s_cycle = '0;
        d_start = 1'b0; d_pc = '0; d_cycle = '0;
        for (int i = 0; i < 32; i++) begin
            s_regs[i] = 32'h0BAD_0000 | 32'(i);
            s_mems[i] = 32'h0F00_0000 | 32'(i);
            d_regs[i] = {8'hA0 + 8'(i), 8'(i), 8'h5A, 8'(~i)};
            d_mems[i] = {8'hB0 ^ 8'(i), 8'(3 * i), 8'hC3, 8'(i + 7)};
        end
        s_regs[0] = 32'h1122_3344;
        s_regs[1] = 32'hAABB_CCDD;
        s_mems[0] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        check(s_tx_start == 0 && d_tx_start == 0, "rst_tx_start", {s_tx_start, d_tx_start}, 0);
        check(s_tx_data == 0 && d_tx_data == 0, "rst_tx_data", {s_tx_data, d_tx_data}, 0);
        check(s_busy == 0 && d_busy == 0, "rst_busy", {s_busy, d_busy}, 0);
        check(s_send_done == 0 && d_send_done == 0, "rst_send_done", {s_send_done, d_send_done}, 0);
        check(s_reg_addr == 0 && d_reg_addr == 0, "rst_reg_addr", {s_reg_addr, d_reg_addr}, 0);
        check(s_mem_addr == 0 && d_mem_addr == 0, "rst_mem_addr", {s_mem_addr, d_mem_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_auto = 1'b1;
        repeat (2) @(negedge clk);

        // Frame with known contents, done 10 cycles after each strobe.
        s_delay = 10;
        s_log.delete();
        s_send(32'h0040_0010, 32'h0000_002A);
        wait_s_frames(1, 2000, "t1_timeout");
        check(s_log.size() == 20, "t1_count", s_log.size(), 20);
        for (int i = 0; i < 20 && i < s_log.size(); i++)
            check(s_log[i] == lit[i], "t1_literal_byte", s_log[i], lit[i]);

        // PC/cycle changes after the start are not seen in the frame.
        repeat (5) @(negedge clk);
        s_log.delete();
        s_send(32'h0040_0010, 32'h0000_002A);
        s_pc = 32'hFFFF_FFFF; s_cycle = 32'h1234_5678;
        wait_s_frames(2, 2000, "t2_timeout");
        for (int i = 0; i < 8 && i < s_log.size(); i++)
            check(s_log[i] == lit[i], "t2_captured_byte", s_log[i], lit[i]);

        // Start requests while busy are dropped.
        repeat (5) @(negedge clk);
        s_log.delete();
        s_send(32'h0000_0001, 32'h0000_0002);
        for (int i = 0; i < 6; i++) begin
            repeat (30) @(negedge clk);
            check(s_busy == 1'b1, "t3_busy_when_poked", s_busy, 1);
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
        end
        wait_s_frames(3, 2000, "t3_timeout");
        repeat (60) @(negedge clk);
        check(s_log.size() == 20 && s_frames == 3, "t3_single_frame", s_log.size(), 20);

        // i_tx_done pulses while idle produce no strobe.
        s_auto = 1'b0;
        base = s_strobes;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s_tx_done = 1'b1;
            @(negedge clk); s_tx_done = 0;
        end
        repeat (10) @(negedge clk);
        check(s_strobes == base && s_busy == 0, "t3_idle_done", s_strobes - base, 0);
        s_auto = 1'b1;

        // Slow UART: data must hold and no second strobe for 200 cycles.
        s_delay = 200;
        s_send(32'hCAFE_F00D, 32'h0102_0304);
        wait_s_frames(4, 6000, "t4_timeout");
        repeat (5) @(negedge clk);

        // Reset after byte 7 abandons the frame.
        s_delay = 10;
        base = s_strobes;
        s_send(32'h0040_0010, 32'h0000_002A);
        for (int i = 0; i < 1000 && s_strobes < base + 8; i++) @(negedge clk);
        check(s_strobes >= base + 8, "t5_wait_byte7", s_strobes - base, 8);
        repeat (4) @(negedge clk);
        base = s_frames;
        rst_n = 1'b0;
        #1;
        check(s_tx_start == 0 && s_busy == 0 && s_send_done == 0, "t5_rst_ctrl",
              {s_tx_start, s_busy, s_send_done}, 0);
        check(s_tx_data == 0, "t5_rst_data", s_tx_data, 0);
        check(s_reg_addr == 0 && s_mem_addr == 0, "t5_rst_addr", {s_reg_addr, s_mem_addr}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check(s_frames == base, "t5_no_done", s_frames, base);
        s_log.delete();
        s_send(32'h0040_0010, 32'h0000_002A);
        wait_s_frames(base + 1, 2000, "t5_restart_timeout");
        for (int i = 0; i < 4 && i < s_log.size(); i++)
            check(s_log[i] == lit[i], "t5_restart_byte", s_log[i], lit[i]);

        // Default size, immediate done: 264 bytes and full address sweep.
        w[0] = 32'h89AB_CDEF;
        w[1] = 32'h0000_1000;
        for (int i = 0; i < 32; i++) begin
            w[2 + i]  = d_regs[i];
            w[34 + i] = d_mems[i];
        end
        @(negedge clk);
        d_pc = w[0]; d_cycle = w[1]; d_start = 1'b1; d_nbyte = 0;
        foreach (w[i]) for (int b = 0; b < 4; b++) d_exp.push_back(w[i][8*b +: 8]);
        @(negedge clk);
        d_start = 1'b0;
        for (int i = 0; i < 5000 && d_frames < 1; i++) @(negedge clk);
        check(d_frames == 1, "t6_timeout", d_frames, 1);
        repeat (10) @(negedge clk);
        check(d_nbyte == 264 && d_exp.size() == 0, "t6_strobes", d_nbyte, 264);
        check(d_frames == 1 && d_busy == 0, "t6_one_done", d_frames, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks, expected completion", checks);
        $fatal(1);
    end

endmodule
